// File: rtl/mii_rx_framer.sv
// rtl/mii_rx_framer.sv - MII RX nibble framer: strips preamble/SFD, pairs nibbles, tags sof/eof/err into a byte FIFO.
// Define MII_RX_STRIP_FCS_EN to hold back and drop the 4 trailing FCS bytes of each frame.
module mii_rx_framer #(
    parameter int FIFO_DEPTH      = 16,
    parameter int MAX_FRAME_BYTES = 1522
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mii_en,
    input  logic [3:0] mii_d,
    output logic [7:0] rx_data,
    output logic       rx_sof,
    output logic       rx_eof,
    output logic       rx_err,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       ovf
);
`ifdef MII_RX_STRIP_FCS_EN
    localparam int HOLD = 5;
`else
    localparam int HOLD = 1;
`endif
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [2:0]  HOLD_CNT = 3'(HOLD);
    localparam logic [15:0] MAX_CNT  = 16'(MAX_FRAME_BYTES);
    // entry layout: {err, eof, sof, data}
    localparam logic [10:0] ERR_ENTRY = {1'b1, 1'b1, 1'b0, 8'h00};

    typedef enum logic [2:0] {IDLE, PREAM, LO, HI, DROP} state_t;
    state_t state, state_nx;

    logic        en_q;
    logic [3:0]  d_q, low_q;
    logic [7:0]  hold [HOLD];
    logic [2:0]  hold_cnt;
    logic [15:0] byte_cnt;
    logic        first_q, pend_q, pend_wait_q;

    logic [AW:0]  wr_ptr, rd_ptr;
    logic [10:0]  mem [FIFO_DEPTH];
    logic         full, pop, can_push, pend_ok;

    logic        want_push, push_en, closing, odd;
    logic [10:0] want_entry, push_entry;
    logic        shift_in, latch_lo, frame_start, hold_clr;
    logic        pend_set, pend_wait_set, ovf_set, first_clr;

    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rx_valid = (wr_ptr != rd_ptr);
    assign pop      = rx_valid & rx_ready;
    assign can_push = !full || pop;
    assign {rx_err, rx_eof, rx_sof, rx_data} = rx_valid ? mem[rd_ptr[AW-1:0]] : 11'd0;

    always_comb begin
        state_nx      = state;
        want_push     = 1'b0;
        want_entry    = '0;
        push_en       = 1'b0;
        push_entry    = '0;
        closing       = 1'b0;
        odd           = 1'b0;
        shift_in      = 1'b0;
        latch_lo      = 1'b0;
        frame_start   = 1'b0;
        hold_clr      = 1'b0;
        pend_set      = 1'b0;
        pend_wait_set = 1'b0;
        ovf_set       = 1'b0;
        first_clr     = 1'b0;
        pend_ok       = 1'b0;
        case (state)
            IDLE: if (en_q) state_nx = (d_q == 4'h5) ? PREAM : DROP;
            PREAM: begin
                if (!en_q)               state_nx = IDLE;
                else if (d_q == 4'hD) begin
                    state_nx    = LO;
                    frame_start = 1'b1;
                end else if (d_q != 4'h5) state_nx = DROP;
            end
            LO: begin
                if (en_q) begin
                    latch_lo = 1'b1;
                    state_nx = HI;
                end else begin
                    closing  = 1'b1;
                    state_nx = IDLE;
                end
            end
            HI: begin
                if (!en_q) begin
                    closing  = 1'b1;
                    odd      = 1'b1;
                    state_nx = IDLE;
                end else begin
                    // a completed byte releases the oldest held byte
                    if (hold_cnt == HOLD_CNT) begin
                        want_push  = 1'b1;
                        want_entry = {1'b0, 1'b0, first_q, hold[HOLD-1]};
                    end
                    if (byte_cnt == MAX_CNT) begin
                        pend_set      = 1'b1;
                        pend_wait_set = 1'b1;
                        hold_clr      = 1'b1;
                        state_nx      = DROP;
                    end else begin
                        shift_in = 1'b1;
                        state_nx = LO;
                    end
                end
            end
            DROP: if (!en_q) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        if (closing) begin
            hold_clr = 1'b1;
            if (hold_cnt == HOLD_CNT) begin
                want_push  = 1'b1;
                want_entry = {odd, 1'b1, first_q, hold[HOLD-1]};
            end else if (hold_cnt != 3'd0) begin
                want_push  = 1'b1;
                want_entry = {1'b1, 1'b1, 1'b1, 8'h00};
            end
        end

        pend_ok = pend_q && can_push && !(pend_wait_q && en_q);
        if (pend_ok) begin
            push_en    = 1'b1;
            push_entry = ERR_ENTRY;
        end
        if (want_push) begin
            if (can_push && !pend_q) begin
                push_en    = 1'b1;
                push_entry = want_entry;
                first_clr  = 1'b1;
            end else begin
                ovf_set  = 1'b1;
                pend_set = 1'b1;
                shift_in = 1'b0;
                hold_clr = 1'b1;
                state_nx = DROP;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            en_q        <= 1'b0;
            d_q         <= 4'd0;
            low_q       <= 4'd0;
            hold_cnt    <= 3'd0;
            byte_cnt    <= 16'd0;
            first_q     <= 1'b1;
            pend_q      <= 1'b0;
            pend_wait_q <= 1'b0;
            ovf         <= 1'b0;
            for (int i = 0; i < HOLD; i++) hold[i] <= 8'd0;
        end else begin
            state <= state_nx;
            en_q  <= mii_en;
            d_q   <= mii_d;
            ovf   <= ovf_set;
            if (latch_lo) low_q <= d_q;
            if (frame_start || hold_clr) begin
                hold_cnt <= 3'd0;
            end else if (shift_in) begin
                hold[0] <= {d_q, low_q};
                for (int i = 1; i < HOLD; i++) hold[i] <= hold[i-1];
                if (hold_cnt != HOLD_CNT) hold_cnt <= hold_cnt + 3'd1;
            end
            if (frame_start)   byte_cnt <= 16'd0;
            else if (shift_in) byte_cnt <= byte_cnt + 16'd1;
            if (frame_start)    first_q <= 1'b1;
            else if (first_clr) first_q <= 1'b0;
            if (pend_set) begin
                pend_q      <= 1'b1;
                pend_wait_q <= pend_wait_set;
            end else begin
                if (pend_ok) pend_q <= 1'b0;
                if (!en_q)   pend_wait_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr[AW-1:0]] <= push_entry;
    end
endmodule

// File: tb/tb_mii_rx_framer.sv
// tb/tb_mii_rx_framer.sv - scoreboard bench for mii_rx_framer (FIFO_DEPTH=4, MAX_FRAME_BYTES=64).
module tb_mii_rx_framer;
    localparam int MAXB = 64;
`ifdef MII_RX_STRIP_FCS_EN
    localparam int HOLD = 5;
`else
    localparam int HOLD = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mii_en = 1'b0;
    logic [3:0] mii_d = 4'd0;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_sof, rx_eof, rx_err, rx_valid, ovf;

    typedef struct {
        logic [7:0] data;
        logic       sof;
        logic       eof;
        logic       err;
        logic       sof_dc;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad = 0;
    int ovf_cnt = 0;

    always #5 clk = ~clk;

    mii_rx_framer #(.FIFO_DEPTH(4), .MAX_FRAME_BYTES(MAXB)) dut (
        .clk(clk), .rst_n(rst_n), .mii_en(mii_en), .mii_d(mii_d),
        .rx_data(rx_data), .rx_sof(rx_sof), .rx_eof(rx_eof), .rx_err(rx_err),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .ovf(ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic void expect_e(input logic [7:0] d, input logic s, input logic eo,
                                     input logic er, input logic dc);
        exp_t e;
        e.data = d; e.sof = s; e.eof = eo; e.err = er; e.sof_dc = dc;
        sb.push_back(e);
    endfunction

    function automatic void model(input logic [7:0] b[$], input bit odd);
        int n = b.size();
        if (n == 0) return;
        if (n > MAXB) begin
            for (int i = 0; i < MAXB - HOLD + 1; i++) expect_e(b[i], i == 0, 1'b0, 1'b0, 1'b0);
            expect_e(8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
        end else if (n < HOLD) begin
            expect_e(8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
        end else begin
            int last = n - HOLD;
            for (int i = 0; i <= last; i++)
                expect_e(b[i], i == 0, i == last, (i == last) && odd, 1'b0);
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (ovf) ovf_cnt++;
        if (rst_n && rx_valid && rx_ready) begin
            if (sb.size() == 0) begin
                check("extra_entry", {24'd0, rx_data}, 32'h100);
            end else begin
                e = sb.pop_front();
                check("data", {24'd0, rx_data}, {24'd0, e.data});
                check("eof", {31'd0, rx_eof}, {31'd0, e.eof});
                check("err", {31'd0, rx_err}, {31'd0, e.err});
                if (!e.sof_dc) check("sof", {31'd0, rx_sof}, {31'd0, e.sof});
            end
        end
    end

    task automatic nib(input logic en, input logic [3:0] d);
        @(posedge clk);
        #1;
        mii_en = en;
        mii_d  = d;
    endtask

    task automatic preamble();
        repeat (15) nib(1'b1, 4'h5);
        nib(1'b1, 4'hD);
    endtask

    task automatic send_bytes(input logic [7:0] b[$], input bit odd, input logic [3:0] x);
        preamble();
        foreach (b[i]) begin
            nib(1'b1, b[i][3:0]);
            nib(1'b1, b[i][7:4]);
        end
        if (odd) nib(1'b1, x);
        repeat (5) nib(1'b0, 4'h0);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        repeat (5) @(posedge clk);
        @(negedge clk);
        check(tag, sb.size(), 0);
        check({tag, "_idle"}, {31'd0, rx_valid}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] f[$];
        int lens[6];
        lens = '{1, 2, 4, 5, 9, 13};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_data", {24'd0, rx_data}, 32'd0);
        check("rst_sof", {31'd0, rx_sof}, 32'd0);
        check("rst_eof", {31'd0, rx_eof}, 32'd0);
        check("rst_err", {31'd0, rx_err}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rx_ready = 1'b1;

        f = {8'h54, 8'hFF, 8'h01, 8'h21, 8'h23, 8'h24};
        model(f, 1'b0);
        send_bytes(f, 1'b0, 4'h0);
        drain("t1");

        f = {8'hBA};
        model(f, 1'b1);
        send_bytes(f, 1'b1, 4'hC);
        drain("t3");

        repeat (6) nib(1'b1, 4'h5);
        nib(1'b1, 4'h3);
        repeat (4) nib(1'b1, 4'h5);
        nib(1'b1, 4'hD);
        for (int i = 0; i < 8; i++) nib(1'b1, 4'(i));
        repeat (5) nib(1'b0, 4'h0);
        drain("t4");

        f = {};
        for (int i = 0; i < 56; i++) f.push_back(8'($urandom_range(0, 255)));
        f.push_back(8'h64); f.push_back(8'h90); f.push_back(8'h02); f.push_back(8'hFB);
        model(f, 1'b0);
        send_bytes(f, 1'b0, 4'h0);
        drain("t5");

        f = {};
        for (int i = 0; i < MAXB; i++) f.push_back(8'($urandom_range(0, 255)));
        model(f, 1'b0);
        send_bytes(f, 1'b0, 4'h0);
        drain("max_len");

        f = {};
        for (int i = 0; i < MAXB + 6; i++) f.push_back(8'($urandom_range(0, 255)));
        model(f, 1'b0);
        send_bytes(f, 1'b0, 4'h0);
        drain("oversize");

        foreach (lens[k]) begin
            f = {};
            for (int i = 0; i < lens[k]; i++) f.push_back(8'($urandom_range(0, 255)));
            model(f, lens[k] % 2 == 1);
            send_bytes(f, lens[k] % 2 == 1, 4'(lens[k]));
            drain("rand_len");
        end

        rx_ready = 1'b0;
        ovf_cnt = 0;
        f = {8'h54, 8'hFF, 8'h01, 8'h21, 8'h23, 8'h24};
`ifdef MII_RX_STRIP_FCS_EN
        model(f, 1'b0);
`else
        expect_e(8'h54, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_e(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_e(8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_e(8'h21, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_e(8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
`endif
        send_bytes(f, 1'b0, 4'h0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("t2_head", {24'd0, rx_data}, 32'h54);
        check("t2_head_sof", {31'd0, rx_sof}, 32'd1);
        check("t2_ovf", ovf_cnt, (HOLD == 1) ? 1 : 0);
        @(posedge clk);
        #1;
        rx_ready = 1'b1;
        drain("t2");

        rx_ready = 1'b0;
        preamble();
        for (int i = 1; i <= 4; i++) begin
            nib(1'b1, 4'(i));
            nib(1'b1, 4'(i));
        end
        @(posedge clk);
        #1;
        rst_n  = 1'b0;
        mii_en = 1'b0;
        @(negedge clk);
        check("t6_valid", {31'd0, rx_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rx_ready = 1'b1;
        f = {8'h54, 8'hFF, 8'h01, 8'h21, 8'h23, 8'h24};
        model(f, 1'b0);
        send_bytes(f, 1'b0, 4'h0);
        drain("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
